// File: rtl/clock_divider_multi.sv
// clock_divider_multi: independent divider channels, each with programmable period and high time plus a period-start tick.
// Shadowed settings reload only at period boundaries, and all outputs are registered in the Clk_in domain.
module clock_divider_multi #(
    parameter int WIDTH    = 33,
    parameter int CHANNELS = 4
) (
    input  logic                      Clk_in,
    input  logic                      Rst_in,
    input  logic [CHANNELS-1:0]       En,
    input  logic [CHANNELS*WIDTH-1:0] Period,
    input  logic [CHANNELS*WIDTH-1:0] High,
    output logic [CHANNELS-1:0]       Clk_out,
    output logic [CHANNELS-1:0]       Tick
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH:0]   ONE_X = (WIDTH+1)'(1);
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        state_t           state, state_nxt;
        logic [WIDTH-1:0] per, hi, cnt, cnt_nxt, ps, ps_nxt, hs, hs_nxt;
        logic [WIDTH:0]   cnt_inc;
        logic             clk_q, clk_nxt, tick_q, tick_nxt, reload, load;
        assign per        = Period[c*WIDTH +: WIDTH];
        assign hi         = High[c*WIDTH +: WIDTH];
        assign Clk_out[c] = clk_q;
        assign Tick[c]    = tick_q;
        // A start, a wrap and a stopped (Ps=0) channel all begin a fresh period from the live inputs
        always_comb begin
            cnt_inc   = {1'b0, cnt} + ONE_X;
            reload    = state == IDLE || ps == '0 || cnt == ps - ONE;
            load      = reload || !En[c];
            state_nxt = En[c] ? RUN : IDLE;
            ps_nxt    = load ? per : ps;
            hs_nxt    = load ? hi : hs;
            cnt_nxt   = load ? '0 : cnt_inc[WIDTH-1:0];
            tick_nxt  = En[c] && reload && per != '0;
            clk_nxt   = En[c] && (reload ? (hi != '0 && per != '0) : cnt_inc < {1'b0, hs});
        end
        always_ff @(posedge Clk_in) begin
            if (Rst_in) begin
                state  <= IDLE;
                cnt    <= '0;
                ps     <= '0;
                hs     <= '0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                state  <= state_nxt;
                cnt    <= cnt_nxt;
                ps     <= ps_nxt;
                hs     <= hs_nxt;
                clk_q  <= clk_nxt;
                tick_q <= tick_nxt;
            end
        end
    end
endmodule

// File: doc/clock_divider_multi.md
Name: clock_divider_multi

Overview:
- Parametrised, multi-channel successor of the single toggle-type clock divider.
- Each channel generates a divided clock with a programmable integer period and a programmable high time, i.e. a programmable duty cycle, and emits a one-cycle period-start tick.
- Settings reload glitch-free, only at period boundaries.
- Sits between the board clock and slower peripherals (display multiplexing, blinkers, PWM loads). Every output is a registered signal in the Clk_in domain.

Parameters:
- WIDTH, 33, width of the period and high-time fields and of each channel counter.
- CHANNELS, 4, number of independent divider channels.

Ports:
- Clk_in  input  1  single system clock; all logic on posedge.
- Rst_in  input  1  synchronous, active-high reset.
- En  input  CHANNELS  per-channel run enable, bit i for channel i.
- Period  input  CHANNELS*WIDTH  per-channel period in Clk_in cycles; channel i in bits [i*WIDTH +: WIDTH].
- High  input  CHANNELS*WIDTH  per-channel high time in Clk_in cycles; same packing as Period.
- Clk_out  output  CHANNELS  divided clock per channel, registered.
- Tick  output  CHANNELS  one-cycle pulse on the first cycle of every period, registered.

Behaviour:
- Per-channel state:
  - cnt[WIDTH]: position in the current period.
  - Ps[WIDTH], Hs[WIDTH]: shadow copies of Period and High.
  - run: 1 bit.
- Reset: when Rst_in=1 at a posedge, every channel is set to cnt=0, Ps=0, Hs=0, run=0, Clk_out=0, Tick=0. Reset takes priority over all other conditions, including reset asserted mid-period. No output glitch is permitted after reset release.
- Channel states:
  - IDLE (run=0)
  - RUN (run=1)
- IDLE, En[i]=0:
  - cnt=0, Clk_out=0, Tick=0.
  - Shadows load from the inputs every cycle.
- IDLE to RUN (edge where En[i]=1 and run=0):
  - Ps<=Period, Hs<=High, cnt<=0, run<=1.
  - Tick<=1.
  - Clk_out<=(High!=0 && Period!=0).
- RUN, each edge with En[i]=1:
  - If cnt==Ps-1 (wrap):
    - cnt<=0, Ps<=Period, Hs<=High.
    - Tick<=1.
    - Clk_out<=(High!=0 && Period!=0).
  - Otherwise:
    - cnt<=cnt+1, Tick<=0.
    - Clk_out<=((cnt+1)<Hs).
  - Resulting waveform: Clk_out is high for exactly min(Hs,Ps) cycles and low for Ps-min(Hs,Ps) cycles. The period is exactly Ps cycles.
- RUN to IDLE: En[i]=0 at an edge gives run<=0, cnt<=0, Clk_out<=0, Tick<=0 immediately. This abort is intentional and may truncate the high phase.
- Shadow rule: Period and High changes made mid-period have no effect until the next wrap. An in-progress period is never shortened or stretched.
- Boundary values:
  - Ps=0: channel treated as stopped. cnt holds 0, Clk_out=0, Tick=0, and the shadows keep loading every cycle so a new nonzero Period starts on the next edge with Tick=1.
  - Ps=1: wrap every cycle. Tick is constantly 1. Clk_out is constantly (Hs!=0).
  - Hs=0: Clk_out is constantly 0. Ticks still occur.
  - Hs>=Ps: Clk_out is constantly 1 while running.
  - 50% duty: Period=2N, High=N. This reproduces the legacy toggle divider behaviour.
- Arithmetic:
  - The compare uses unsigned WIDTH-bit values.
  - cnt+1 is computed at WIDTH+1 bits so no overflow occurs at Ps=2^WIDTH-1.
- Channels are fully independent. One channel's En, Period or wrap never affects another channel.
- Latency: Clk_out and Tick change on the same Clk_in edge as the cnt update that defines them. There is no combinational path from any input to any output.

Test Plan:
- Reset and idle: Rst_in=1 for 3 cycles with En=4'b1111 -> Clk_out=0 and Tick=0 throughout. Release reset -> all channels start on the next edge with Tick=1.
- Duty cycle: ch0 Period=5, High=2, En=1 -> repeating Clk_out pattern 1,1,0,0,0 and Tick pattern 1,0,0,0,0, for 20 periods.
- Legacy equivalence: ch1 Period=8, High=4 -> square wave of 4 high and 4 low cycles, 50% duty, Tick every 8 cycles.
- Mid-period reload: ch2 running Period=10, High=3; at cnt=4 write Period=4, High=1 -> current period finishes at 10 cycles, then the pattern becomes 1,0,0,0 with no glitch.
- Boundaries:
  - Period=1, High=1 -> Clk_out=1 and Tick=1 constant.
  - Period=0 -> Clk_out=0 and no Tick.
  - High=0 -> Clk_out=0 with Tick still every Period cycles.
  - High=7, Period=3 -> Clk_out=1 constant.
- Independence and abort:
  - Four channels on co-prime periods 3, 5, 7, 11 -> each period is exact over 1155 cycles.
  - Drop En[3] mid-high phase -> Clk_out[3]=0 on the next edge, and channels 0-2 are undisturbed.
  - Assert Rst_in mid-period -> all outputs are 0 on the next edge.
